pixel_window_gen: RTL and testbench

//  Streaming KxK neighbourhood generator for the edge-detect datapath. Accepts one raster-order

---
 rtl/pixel_window_pkg.sv | 21 ++
 rtl/pixel_window_if.sv | 34 +++
 rtl/pixel_line_buf.sv | 24 ++
 rtl/pixel_window_gen.sv | 186 ++++++++++++++++++
 tb/tb_pixel_window_gen.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_window_pkg.sv
// Shared types and helpers for the KxK pixel window generator.
// Window element (r,c) lives at bit offset win_idx(r,c,...) of the flattened window bus.
package pixel_window_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int unsigned K_MIN = 3;
    localparam int unsigned K_MAX = 7;

    // Legal geometry: odd K in [K_MIN, K_MAX] that fits inside the frame.
    function automatic bit cfg_ok(input int unsigned k, input int unsigned w,
                                  input int unsigned h);
        return (k % 2 == 1) && (k >= K_MIN) && (k <= K_MAX) && (k <= w) && (k <= h);
    endfunction

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned k, input int unsigned pix_w);
        return (r * k + c) * pix_w;
    endfunction

endpackage

// File: rtl/pixel_window_if.sv
// Pixel-in / window-out stream bundle. Optional framing flags when PIX_WINDOW_FLAGS_EN
// is defined. master = stream environment, slave = window generator.
interface pixel_window_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned K     = 3
);
    logic [PIX_W-1:0]     in_pixel;
    logic                 in_valid;
    logic                 in_ready;
    logic [K*K*PIX_W-1:0] win_pixels;
    logic                 win_valid;
    logic                 win_ready;
`ifdef PIX_WINDOW_FLAGS_EN
    logic                 win_sof;
    logic                 win_eof;
`endif

    modport master (
        output in_pixel, in_valid, win_ready,
        input  in_ready, win_pixels, win_valid
`ifdef PIX_WINDOW_FLAGS_EN
        , input win_sof, win_eof
`endif
    );

    modport slave (
        input  in_pixel, in_valid, win_ready,
        output in_ready, win_pixels, win_valid
`ifdef PIX_WINDOW_FLAGS_EN
        , output win_sof, win_eof
`endif
    );

endinterface

// File: rtl/pixel_line_buf.sv
// One image line of storage with registered read. Read and write ports are addressed
// independently; on an address collision the old word is returned.
module pixel_line_buf #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [PIX_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [PIX_W-1:0]         rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_window_gen.sv
// Streaming KxK neighbourhood generator: buffers K-1 lines and emits one window per interior
// pixel. Define PIX_WINDOW_FLAGS_EN to add win_sof/win_eof framing flags on the window bus.
module pixel_window_gen
    import pixel_window_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned K     = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    pixel_window_if.slave bus,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    if (!cfg_ok(K, IMG_W, IMG_H)) begin : g_bad_cfg
        $error("pixel_window_gen: K must be odd, 3..7, and no larger than the frame");
    end

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic in_ready, accept, load, last_pix, win_valid_q;

    logic [PIX_W-1:0] win_q   [K][K];
    logic [PIX_W-1:0] new_col [K];
    logic [PIX_W-1:0] lb_wr   [K-1];
    logic [PIX_W-1:0] lb_rd   [K-1];
    logic [K*K*PIX_W-1:0] win_flat;

    assign accept   = bus.in_valid && in_ready;
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign load     = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = FLUSH;
            FLUSH:   if (!win_valid_q || bus.win_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q != IDLE);
        in_ready = (state_q == RUN) && (!win_valid_q || bus.win_ready);
        done     = (state_q == FLUSH) && (!win_valid_q || bus.win_ready);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == IDLE && start) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Reads are issued for the next column so the word above the incoming pixel is already
    // registered when that pixel is accepted; line i+1 takes line i's outgoing word.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        if (i == 0) begin : g_head
            assign lb_wr[i] = bus.in_pixel;
        end else begin : g_chain
            assign lb_wr[i] = lb_rd[i-1];
        end

        pixel_line_buf #(
            .PIX_W (PIX_W),
            .DEPTH (IMG_W)
        ) u_line_buf (
            .clk     (clk),
            .wr_en   (accept),
            .wr_addr (col_q),
            .wr_data (lb_wr[i]),
            .rd_addr (col_d),
            .rd_data (lb_rd[i])
        );
    end

    // Bottom row is the live pixel; older lines sit higher in the window.
    assign new_col[K-1] = bus.in_pixel;
    for (genvar r = 0; r < K - 1; r++) begin : g_col
        assign new_col[r] = lb_rd[K-2-r];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_valid_q <= 1'b0;
        end else if (load) begin
            win_valid_q <= 1'b1;
        end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                win_flat[win_idx(r, c, K, PIX_W) +: PIX_W] = win_q[r][c];
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_pixels = win_flat;

`ifdef PIX_WINDOW_FLAGS_EN
    logic sof_q, eof_q, first_win;

    assign first_win = (row_q == ROW_FIRST) && (col_q == COL_FIRST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sof_q <= 1'b0;
            eof_q <= 1'b0;
        end else if (load) begin
            sof_q <= first_win;
            eof_q <= last_pix;
        end
    end

    assign bus.win_sof = sof_q;
    assign bus.win_eof = eof_q;
`endif

endmodule

// File: tb/tb_pixel_window_gen.sv
// Scoreboard bench for pixel_window_gen: a 4x4/K=3 instance and a 6x6/K=5 instance.
// Expected windows are pushed as pixels are driven; monitors pop and compare on handshake.
`timescale 1ns/1ps
module tb_pixel_window_gen;

    localparam int AW = 4, AH = 4, AK = 3;
    localparam int BW = 6, BH = 6, BK = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b, busy_a, busy_b, done_a, done_b;

    pixel_window_if #(.PIX_W(8), .K(AK)) ifa ();
    pixel_window_if #(.PIX_W(8), .K(BK)) ifb ();

    pixel_window_gen #(.PIX_W(8), .IMG_W(AW), .IMG_H(AH), .K(AK)) u_dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .bus(ifa), .busy(busy_a), .done(done_a)
    );
    pixel_window_gen #(.PIX_W(8), .IMG_W(BW), .IMG_H(BH), .K(BK)) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .bus(ifb), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] flat;
        bit           sof;
        bit           eof;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int errors = 0, checks = 0;
    int a_wins = 0, a_dones = 0, b_wins = 0, b_dones = 0;
    logic [255:0] a_first, b_first;
    bit a_got_first = 0, b_got_first = 0;

    task automatic check_win(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        logic [31:0] rr, cc;
        rr = r;
        cc = c;
        return {rr[3:0], cc[3:0]};
    endfunction

    function automatic logic [255:0] exp_win(input int k, input int cr, input int cc);
        logic [255:0] v;
        int h;
        v = '0;
        h = (k - 1) / 2;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                v[(r*k+c)*8 +: 8] = pix(cr - h + r, cc - h + c);
        return v;
    endfunction

    task automatic monitor_a();
        forever begin
            @(negedge clk);
            if (ifa.win_valid) begin
                if (qa.size() == 0) begin
                    check_int("a_unexpected_window", 1, 0);
                end else begin
                    check_win("a_window", 256'(ifa.win_pixels), qa[0].flat);
`ifdef PIX_WINDOW_FLAGS_EN
                    check_int("a_sof", int'(ifa.win_sof), int'(qa[0].sof));
                    check_int("a_eof", int'(ifa.win_eof), int'(qa[0].eof));
`endif
                    if (ifa.win_ready) begin
                        if (!a_got_first) begin
                            a_first = 256'(ifa.win_pixels);
                            a_got_first = 1;
                        end
                        void'(qa.pop_front());
                        a_wins++;
                    end
                end
                if (!ifa.win_ready) check_int("a_in_ready_stall", int'(ifa.in_ready), 0);
            end
            if (done_a) a_dones++;
        end
    endtask

    task automatic monitor_b();
        forever begin
            @(negedge clk);
            if (ifb.win_valid) begin
                if (qb.size() == 0) begin
                    check_int("b_unexpected_window", 1, 0);
                end else begin
                    check_win("b_window", 256'(ifb.win_pixels), qb[0].flat);
`ifdef PIX_WINDOW_FLAGS_EN
                    check_int("b_sof", int'(ifb.win_sof), int'(qb[0].sof));
                    check_int("b_eof", int'(ifb.win_eof), int'(qb[0].eof));
`endif
                    if (ifb.win_ready) begin
                        if (!b_got_first) begin
                            b_first = 256'(ifb.win_pixels);
                            b_got_first = 1;
                        end
                        void'(qb.pop_front());
                        b_wins++;
                    end
                end
            end
            if (done_b) b_dones++;
        end
    endtask

    task automatic drive_a(input int r, input int c);
        int n = 0;
        bit acc = 0;
        exp_t e;
        ifa.in_pixel = pix(r, c);
        ifa.in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ifa.in_ready;
            n++;
        end
        if (!acc) check_int("a_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        ifa.in_pixel = 8'hee;
        if (acc && r >= AK - 1 && c >= AK - 1) begin
            e.flat = exp_win(AK, r - 1, c - 1);
            e.sof  = (r == AK - 1) && (c == AK - 1);
            e.eof  = (r == AH - 1) && (c == AW - 1);
            qa.push_back(e);
        end
    endtask

    task automatic drive_b(input int r, input int c, input int gap);
        int n = 0;
        bit acc = 0;
        exp_t e;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        ifb.in_pixel = pix(r, c);
        ifb.in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ifb.in_ready;
            n++;
        end
        if (!acc) check_int("b_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
        ifb.in_pixel = 8'h5a;
        if (acc && r >= BK - 1 && c >= BK - 1) begin
            e.flat = exp_win(BK, r - 2, c - 2);
            e.sof  = (r == BK - 1) && (c == BK - 1);
            e.eof  = (r == BH - 1) && (c == BW - 1);
            qb.push_back(e);
        end
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? busy_b : busy_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int(sel ? "b_frame_idle" : "a_frame_idle", int'(sel ? busy_b : busy_a), 0);
    endtask

    // stall: cycles win_ready is held low at the first window; stop_after: 0 = full frame
    task automatic frame_a(input int stall, input bit mid_start, input int stop_after);
        int n = 0;
        int d0 = a_dones;
        int w0 = a_wins;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int r = 0; r < AH; r++) begin
            for (int c = 0; c < AW; c++) begin
                if (stop_after != 0 && n == stop_after) return;
                if (stall != 0 && n == 10) ifa.win_ready = 1'b0;
                if (mid_start && n == 6) start_a = 1'b1;
                drive_a(r, c);
                start_a = 1'b0;
                n++;
                if (n == 10) check_int("a_no_window_before_11th", int'(ifa.win_valid), 0);
                if (n == 11) begin
                    check_int("a_window_after_11th", int'(ifa.win_valid), 1);
                    if (stall != 0) begin
                        repeat (stall) @(negedge clk);
                        @(posedge clk);
                        #1;
                        ifa.win_ready = 1'b1;
                    end
                end
            end
        end
        wait_idle(1'b0);
        check_int("a_window_count", a_wins - w0, 4);
        check_int("a_done_once", a_dones - d0, 1);
        check_int("a_queue_empty", qa.size(), 0);
    endtask

    task automatic frame_b();
        int d0 = b_dones;
        int w0 = b_wins;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++)
                drive_b(r, c, int'($urandom_range(2, 0)));
        wait_idle(1'b1);
        check_int("b_window_count", b_wins - w0, 4);
        check_int("b_done_once", b_dones - d0, 1);
        check_int("b_queue_empty", qb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_pixel = '0;
        ifa.win_ready = 1'b1;
        ifb.in_valid = 1'b0;
        ifb.in_pixel = '0;
        ifb.win_ready = 1'b1;
        fork
            monitor_a();
            monitor_b();
        join_none
        #1 rst_n = 1'b0;
        #1;
        check_int("reset_busy", int'(busy_a), 0);
        check_int("reset_in_ready", int'(ifa.in_ready), 0);
        check_int("reset_win_valid", int'(ifa.win_valid), 0);
        check_int("reset_done", int'(done_a), 0);
        check_win("reset_win_pixels", 256'(ifa.win_pixels), '0);
        check_int("reset_b_win_valid", int'(ifb.win_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 4x4 frame plus hand-computed first-window checks
        frame_a(0, 1'b0, 0);
        check_int("a_first_centre", int'(a_first[32 +: 8]), 'h11);
        check_int("a_first_row0", int'(a_first[0 +: 24]), 'h020100);
        check_int("a_first_row2", int'(a_first[48 +: 24]), 'h222120);

        // Backpressure at the first window
        frame_a(5, 1'b0, 0);

        // Start pulse while busy
        frame_a(0, 1'b1, 0);

        // Reset after 9 pixels, then a clean frame
        frame_a(0, 1'b0, 9);
        d0 = a_dones;
        rst_n = 1'b0;
        #1;
        check_int("midreset_busy", int'(busy_a), 0);
        check_int("midreset_in_ready", int'(ifa.in_ready), 0);
        check_int("midreset_win_valid", int'(ifa.win_valid), 0);
        check_win("midreset_win_pixels", 256'(ifa.win_pixels), '0);
        qa.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_int("midreset_no_done", a_dones - d0, 0);
        frame_a(0, 1'b0, 0);

        // K=5 on a 6x6 frame with input gaps
        frame_b();
        check_int("b_first_centre", int'(b_first[96 +: 8]), 'h22);
        check_int("b_first_row0", int'(b_first[0 +: 32]), 'h03020100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
